// File: rtl/serial_arb_pkg.sv
// Shared types and sizing helpers for the two-client serial adder scheduler.
package serial_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_slice.sv
// One-bit full adder with a carry flop that can be preloaded, advanced or cleared.
module serial_add_slice (
   input  logic clk,
   input  logic clr_n,
   input  logic load,
   input  logic cin,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);

   logic c;

   always_comb begin
      s  = a ^ b ^ c;
      co = (a & b) | (a & c) | (b & c);
   end

   // NOTE: state is written with <= so every flop samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!clr_n)
         c <= 1'b0;
      else if (load)
         c <= cin;
      else if (en)
         c <= co;
   end

endmodule

// File: rtl/serial_adder_arbiter.sv
// Round-robin scheduler sharing one bit-serial adder between two requesters;
// LSB-first addition over WIDTH cycles with a req/gnt/done handshake.
module serial_adder_arbiter
   import serial_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             cin0,
   input  logic             cin1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] sum_sr;
   logic [WIDTH-1:0] sum_nxt;
   logic [CW-1:0]    cnt;
   logic             last_id;
   logic             any_req, pick1, grant, shifting, last_bit;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic             cin_sel;
   logic             s_bit, c_next;

   // pick1: requester 1 wins when alone, or when both ask and 0 was served last.
   always_comb begin
      any_req  = req0 | req1;
      pick1    = req1 & (~req0 | ~last_id);
      grant    = (state == IDLE) & any_req;
      shifting = (state == SHIFT);
      last_bit = (cnt == CW'(WIDTH - 1));
      a_sel    = pick1 ? a1 : a0;
      b_sel    = pick1 ? b1 : b0;
      cin_sel  = pick1 ? cin1 : cin0;
      sum_nxt  = {s_bit, sum_sr};
   end

   serial_add_slice u_slice (
      .clk   (clk),
      .clr_n (rst),
      .load  (grant),
      .cin   (cin_sel),
      .en    (shifting),
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .s     (s_bit),
      .co    (c_next)
   );

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: assign the default first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         cnt     <= '0;
         last_id <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  a_sr    <= a_sel;
                  b_sr    <= b_sel;
                  cnt     <= '0;
                  gnt0    <= ~pick1;
                  gnt1    <= pick1;
                  done_id <= pick1;
                  last_id <= pick1;
                  busy    <= 1'b1;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_nxt[WIDTH-1:1];
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  sum  <= sum_nxt;
                  cout <= c_next;
                  done <= 1'b1;
               end
            end
            DONE: begin
               done <= 1'b0;
               gnt0 <= 1'b0;
               gnt1 <= 1'b0;
               busy <= 1'b0;
            end
            default: begin
               done <= 1'b0;
               gnt0 <= 1'b0;
               gnt1 <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Round-robin scheduler that shares one bit-serial adder datapath between two requesters. It owns the operand shift registers, the bit counter and the carry flop, and it sequences LSB-first addition over WIDTH cycles. It sits between two client blocks and the serial add slice, and replaces testbench-driven load/shift sequencing with a req/gnt/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; all state and outputs are cleared on a clk edge with rst=0
- req0, req1  in  1  request; held high with operands stable until the matching done pulse
- a0, b0, a1, b1  in  WIDTH  operands, sampled only on the grant edge
- cin0, cin1  in  1  carry-in, sampled on the grant edge
- gnt0, gnt1  out  1  grant, one-hot or zero; registered
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle result-valid pulse
- done_id  out  1  requester served by the current or last operation
- sum  out  WIDTH  result register; holds its value until the next done
- cout  out  1  final carry; holds its value with sum

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on an edge with any req high:
  - pick the winner, load its a/b into shift regs and its cin into the carry flop
  - clear cnt, set the winner's gnt, set done_id, go to SHIFT.
  - With no req: stay in IDLE, outputs unchanged.
- Arbitration: round-robin on last_id.
  - When both req are high, grant the one ≠ last_id; otherwise grant the sole requester.
  - last_id resets to 1, so req0 wins the first contention after reset.
  - last_id updates on grant.
- SHIFT, each edge:
  - s = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0], b_sr[0], c)
  - s shifts into the MSB of sum_sr; a_sr and b_sr shift right
  - cnt increments
  - At cnt==WIDTH-1, go to DONE, copy the completed sum_sr into sum, and the final carry into cout.
- DONE: done=1 for exactly one cycle and gnt stays high. The next edge clears gnt and returns to IDLE.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Dropping req during SHIFT is ignored: the operation completes and done still pulses.
- The non-granted req is held pending and is served at the first IDLE edge.
- A req still high in IDLE after its done counts as a new request. Clients drop req on the done cycle.
- rst=0 at any edge, including mid-SHIFT:
  - operation aborted, no done
  - state IDLE; gnt0/gnt1/busy/done/done_id/sum/cout all 0
  - cnt, shift regs and carry cleared; last_id=1

## Timing
- Let k be the grant edge, where req is sampled high in IDLE.
  - gnt and busy are high from k.
  - done, sum and cout are valid after edge k+WIDTH.
  - IDLE is reached after edge k+WIDTH+1.
- Latency from req sampled to done is WIDTH+1 edges. Back-to-back throughput is one operation per WIDTH+2 cycles.
- A pending competitor is granted at edge k+WIDTH+2 when its req is held.
- Outputs are registered; there are no combinational paths from req to gnt.

## Structure
- Package serial_arb_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - default WIDTH constant
  - counter width = clog2(WIDTH)
- Sub-module serial_add_slice: 1-bit full adder plus carry flop with synchronous load (cin), enable, and active-low synchronous clear. It is instantiated once.
- The top level holds the FSM, arbiter, counter, shift registers and result registers.

## Test plan
- Reset, then req0 with a0=8'h06, b0=8'h0E, cin0=0 → gnt0 at k, done at k+8, sum=8'h14, cout=0, done_id=0.
- req1 with a1=8'hFF, b1=8'h01, cin1=0 → sum=8'h00, cout=1. Then a1=8'h7F, b1=8'h80, cin1=1 → sum=8'h00, cout=1.
- Contention:
  - req0 and req1 raised in the same cycle after reset → req0 served first (done_id=0).
  - req1 is granted exactly 10 cycles after the first grant (done_id=1).
  - A repeat contention then serves req0 again.
- rst=0 asserted mid-SHIFT (cnt=3) → next edge gives all outputs 0, no done pulse. The held req0 is then granted again with fresh operands.
- req0 dropped during SHIFT → done still pulses with the correct sum. Operands changed after the grant have no effect on the result.
- Back-to-back req0 held continuously → new grant every 10 cycles; sum/cout stay stable between done pulses.
